// File: rtl/ieeedrv_pkg.sv
// Shared types and constants for the ieee_drive SD channel arbiter.
package ieeedrv_pkg;
   typedef enum logic {OP_RD, OP_WR} sd_op_t;
   typedef enum logic [1:0] {IDLE, ISSUE, XFER} arb_state_t;
   localparam int SD_BLK_CNT_W = 6;
endpackage

// File: rtl/ieeedrv_rr_pick.sv
// Combinational round-robin pick: first requester at or after rr_ptr, wrapping modulo NBD.
module ieeedrv_rr_pick #(
   parameter int NBD = 2,
   parameter int GW  = 1
) (
   input  logic [NBD-1:0] req,
   input  logic [GW-1:0]  rr_ptr,
   output logic           vld,
   output logic [GW-1:0]  idx
);
   int j;

   // Scan offsets from farthest to nearest so the nearest requester is the last one written.
   always_comb begin
      vld = 1'b0;
      idx = '0;
      j   = 0;
      for (int k = NBD - 1; k >= 0; k--) begin
         j = int'(rr_ptr) + k;
         if (j >= NBD) j = j - NBD;
         if (req[j]) begin
            vld = 1'b1;
            idx = GW'(j);
         end
      end
   end
endmodule

// File: rtl/ieeedrv_sd_arb.sv
// Round-robin arbiter sharing one hps_io SD block channel among NBD drive block devices.
// Optional watchdog and sticky timeout port: define IEEEDRV_SD_ARB_TIMEOUT_EN.
module ieeedrv_sd_arb
   import ieeedrv_pkg::*;
#(
   parameter int          NBD            = 2,
   parameter logic [23:0] TIMEOUT_CYCLES = 24'd16_000_000,
   parameter int          GW             = (NBD > 1) ? $clog2(NBD) : 1
) (
   input  logic                                  clk_sys,
   input  logic                                  reset_n,
   input  logic [NBD-1:0][31:0]                  dev_lba,
   input  logic [NBD-1:0][SD_BLK_CNT_W-1:0]      dev_blk_cnt,
   input  logic [NBD-1:0]                        dev_rd,
   input  logic [NBD-1:0]                        dev_wr,
   output logic [NBD-1:0]                        dev_ack,
   input  logic [NBD-1:0][7:0]                   dev_buff_din,
   output logic [NBD-1:0]                        dev_buff_wr,
   output logic [31:0]                           sd_lba,
   output logic [SD_BLK_CNT_W-1:0]               sd_blk_cnt,
   output logic                                  sd_rd,
   output logic                                  sd_wr,
   input  logic                                  sd_ack,
   input  logic                                  sd_buff_wr,
   output logic [7:0]                            sd_buff_din,
   output logic                                  busy,
`ifdef IEEEDRV_SD_ARB_TIMEOUT_EN
   output logic                                  timeout,
`endif
   output logic [GW-1:0]                         grant
);
   arb_state_t    state;
   sd_op_t        op;
   logic [GW-1:0] rr_ptr;
   logic [GW-1:0] nxt_ptr;
   logic          pick_vld;
   logic [GW-1:0] pick_idx;
   logic          cancel;

   ieeedrv_rr_pick #(.NBD(NBD), .GW(GW)) u_pick (
      .req    (dev_rd | dev_wr),
      .rr_ptr (rr_ptr),
      .vld    (pick_vld),
      .idx    (pick_idx)
   );

   assign nxt_ptr = (grant == GW'(NBD - 1)) ? '0 : grant + GW'(1);
   assign cancel  = !(dev_rd[grant] | dev_wr[grant]);

`ifdef IEEEDRV_SD_ARB_TIMEOUT_EN
   logic [23:0] wd;
   logic        leave;
   assign leave = (state == IDLE  && pick_vld) ||
                  (state == ISSUE && (sd_ack || cancel)) ||
                  (state == XFER  && !sd_ack);
`endif

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         op         <= OP_RD;
         grant      <= '0;
         rr_ptr     <= '0;
         busy       <= 1'b0;
         sd_lba     <= '0;
         sd_blk_cnt <= '0;
`ifdef IEEEDRV_SD_ARB_TIMEOUT_EN
         wd         <= '0;
         timeout    <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: if (pick_vld) begin
               grant      <= pick_idx;
               sd_lba     <= dev_lba[pick_idx];
               sd_blk_cnt <= dev_blk_cnt[pick_idx];
               op         <= dev_rd[pick_idx] ? OP_RD : OP_WR;
               busy       <= 1'b1;
               state      <= ISSUE;
            end
            ISSUE: if (sd_ack) begin
               state <= XFER;
            end else if (cancel) begin
               busy   <= 1'b0;
               rr_ptr <= nxt_ptr;
               state  <= IDLE;
            end
            XFER: if (!sd_ack) begin
               busy   <= 1'b0;
               rr_ptr <= nxt_ptr;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
`ifdef IEEEDRV_SD_ARB_TIMEOUT_EN
         // Watchdog overrides whatever the FSM decided this edge.
         if (state != IDLE && wd == TIMEOUT_CYCLES - 24'd1) begin
            busy    <= 1'b0;
            rr_ptr  <= nxt_ptr;
            state   <= IDLE;
            timeout <= 1'b1;
            wd      <= '0;
         end else if (leave || state == IDLE) begin
            wd <= '0;
         end else begin
            wd <= wd + 24'd1;
         end
`endif
      end
   end

   // Request strobes are a pure decode of registered state, so they drop on the ack edge.
   assign sd_rd = (state == ISSUE) && (op == OP_RD);
   assign sd_wr = (state == ISSUE) && (op == OP_WR);

   for (genvar i = 0; i < NBD; i++) begin : g_dev
      assign dev_ack[i]     = sd_ack     & busy & (grant == GW'(i));
      assign dev_buff_wr[i] = sd_buff_wr & busy & (grant == GW'(i));
   end

   assign sd_buff_din = busy ? dev_buff_din[grant] : 8'h00;
endmodule

// File: tb/tb_ieeedrv_sd_arb.sv
// Directed bench for ieeedrv_sd_arb (NBD=2): grant, routing, cancel, rr wrap and reset abort.
module tb_ieeedrv_sd_arb;
   import ieeedrv_pkg::*;
   localparam int NBD = 2;
   localparam int GW  = 1;

   logic                                   clk_sys = 1'b0;
   logic                                   reset_n = 1'b0;
   logic [NBD-1:0][31:0]                   dev_lba = '0;
   logic [NBD-1:0][SD_BLK_CNT_W-1:0]       dev_blk_cnt = '0;
   logic [NBD-1:0]                         dev_rd = '0;
   logic [NBD-1:0]                         dev_wr = '0;
   logic [NBD-1:0]                         dev_ack;
   logic [NBD-1:0][7:0]                    dev_buff_din = '0;
   logic [NBD-1:0]                         dev_buff_wr;
   logic [31:0]                            sd_lba;
   logic [SD_BLK_CNT_W-1:0]                sd_blk_cnt;
   logic                                   sd_rd, sd_wr;
   logic                                   sd_ack = 1'b0;
   logic                                   sd_buff_wr = 1'b0;
   logic [7:0]                             sd_buff_din;
   logic                                   busy;
   logic [GW-1:0]                          grant;
`ifdef IEEEDRV_SD_ARB_TIMEOUT_EN
   logic                                   timeout;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   ieeedrv_sd_arb #(
      .NBD(NBD)
`ifdef IEEEDRV_SD_ARB_TIMEOUT_EN
      , .TIMEOUT_CYCLES(24'd100)
`endif
   ) dut (
      .clk_sys      (clk_sys),
      .reset_n      (reset_n),
      .dev_lba      (dev_lba),
      .dev_blk_cnt  (dev_blk_cnt),
      .dev_rd       (dev_rd),
      .dev_wr       (dev_wr),
      .dev_ack      (dev_ack),
      .dev_buff_din (dev_buff_din),
      .dev_buff_wr  (dev_buff_wr),
      .sd_lba       (sd_lba),
      .sd_blk_cnt   (sd_blk_cnt),
      .sd_rd        (sd_rd),
      .sd_wr        (sd_wr),
      .sd_ack       (sd_ack),
      .sd_buff_wr   (sd_buff_wr),
      .sd_buff_din  (sd_buff_din),
      .busy         (busy),
`ifdef IEEEDRV_SD_ARB_TIMEOUT_EN
      .timeout      (timeout),
`endif
      .grant        (grant)
   );

   always #5 clk_sys = ~clk_sys;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
   task automatic step(input int n = 1);
      repeat (n) @(posedge clk_sys);
      #1;
   endtask

   initial begin
      #3;
      chk("rst_busy",  busy, 0);
      chk("rst_rdwr",  {sd_rd, sd_wr}, 0);
      chk("rst_lba",   sd_lba, 0);
      chk("rst_grant", grant, 0);
      step(2);
      reset_n = 1'b1;
      step();

      // Ack while idle must not reach any device.
      sd_ack = 1'b1;
      #1 chk("idle_ack_dev", dev_ack, 2'b00);
      step();
      chk("idle_ack_busy", busy, 0);
      sd_ack = 1'b0;
      step();

      // Single read from device 0.
      dev_lba[0] = 32'h100; dev_blk_cnt[0] = 6'd0; dev_rd = 2'b01;
      #1 chk("rd_t0", sd_rd, 0);
      step();
      chk("rd_t1", {busy, sd_rd, sd_wr}, 3'b110);
      chk("rd_lba", sd_lba, 32'h100);
      chk("rd_grant", grant, 0);
      dev_lba[0] = 32'h200;
      step(2);
      chk("rd_hold", sd_rd, 1);
      chk("rd_lba_latched", sd_lba, 32'h100);
      sd_ack = 1'b1;
      #1 chk("rd_dev_ack", dev_ack, 2'b01);
      step();
      dev_rd = 2'b00;
      chk("rd_drop_on_ack", sd_rd, 0);
      step(19);
      chk("rd_ack_mirror", dev_ack, 2'b01);
      sd_ack = 1'b0;
      #1 chk("rd_ack_low", {busy, dev_ack}, 3'b100);
      step();
      chk("rd_busy_fall", busy, 0);

      // Contention from a fresh reset: dev0 first, then dev1, then wrap back to dev0.
      reset_n = 1'b0; step(); reset_n = 1'b1;
      dev_lba[1] = 32'hABCD; dev_blk_cnt[1] = 6'd5;
      dev_rd = 2'b01; dev_wr = 2'b10;
      step();
      chk("ct_g0", {grant, sd_rd, sd_wr}, 3'b010);
      sd_ack = 1'b1; step(); dev_rd = 2'b00;
      sd_ack = 1'b0; step();
      chk("ct_idle", busy, 0);
      chk("ct_din_idle", sd_buff_din, 8'h00);
      step();
      chk("ct_g1", {grant, sd_rd, sd_wr}, 3'b101);
      chk("ct_lba1", {sd_lba, 2'b00, sd_blk_cnt}, {32'hABCD, 8'd5});

      // Buffer routing to device 1.
      sd_ack = 1'b1; step();
      dev_buff_din[1] = 8'hA5; dev_buff_din[0] = 8'h3C; sd_buff_wr = 1'b1;
      #1 chk("buf_din", sd_buff_din, 8'hA5);
      chk("buf_wr", dev_buff_wr, 2'b10);
      chk("buf_ack", dev_ack, 2'b10);
      step(); sd_buff_wr = 1'b0; dev_wr = 2'b00;
      #1 chk("buf_wr_off", dev_buff_wr, 2'b00);
      sd_ack = 1'b0; step(2);
      dev_rd = 2'b01; dev_wr = 2'b10;
      step();
      chk("ct_wrap_g0", {grant, sd_rd, sd_wr}, 3'b010);

      // Cancel: device 0 withdraws in ISSUE, device 1 gets the channel next.
      dev_rd = 2'b00;
      step();
      chk("cn_drop", {busy, sd_rd, sd_wr}, 3'b000);
      chk("cn_no_ack", dev_ack, 2'b00);
      step();
      chk("cn_next_g1", {grant, sd_wr}, 2'b11);

      // Reset mid-XFER clears everything asynchronously.
      sd_ack = 1'b1; step(); dev_wr = 2'b00;
      chk("rx_in_xfer", {busy, dev_ack}, 3'b110);
      #2 reset_n = 1'b0;
      #1 chk("rx_outs", {busy, sd_rd, sd_wr, grant, dev_ack}, 0);
      chk("rx_lba", {sd_lba, 2'b00, sd_blk_cnt}, 0);
      sd_ack = 1'b0;
      step(); reset_n = 1'b1; step();
      dev_rd = 2'b11;
      step();
      chk("rx_rr0", {grant, sd_rd}, 2'b01);
      dev_rd = 2'b00;
      step();
      chk("rx_cancel", busy, 0);

`ifdef IEEEDRV_SD_ARB_TIMEOUT_EN
      begin
         int hi;
         hi = 0;
         dev_rd = 2'b01;
         step();
         while (sd_rd && hi < 300) begin hi++; step(); end
         chk("to_cycles", hi, 100);
         chk("to_flags", {timeout, busy, sd_rd}, 3'b100);
         dev_rd = 2'b00;
      end
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/ieeedrv_sd_arb.md
Name: ieeedrv_sd_arb

Overview:
Shares one MiSTer SD block channel (single sd_lba/sd_rd/sd_wr/sd_ack) among NBD drive subunit block devices.
- Sits between the ieee_drive per-device sd_* ports and the hps_io single-device interface.
- Arbitrates round-robin, locks the grant for a whole transfer, and routes buffer traffic to the granted device only.

Parameters:
NBD, 2, number of block devices (1..8); index width GW = max(1, $clog2(NBD)).
TIMEOUT_CYCLES, 24'd16_000_000, watchdog limit in clk_sys cycles (used only with the optional feature).

Ports:
clk_sys  in  1  system clock.
reset_n  in  1  asynchronous, active-low reset.
dev_lba  in  32 x NBD  per-device LBA.
dev_blk_cnt  in  6 x NBD  per-device block count minus one.
dev_rd  in  NBD  per-device read request, level, held until its dev_ack rises.
dev_wr  in  NBD  per-device write request, same rules as dev_rd.
dev_ack  out  NBD  per-device acknowledge.
dev_buff_din  in  8 x NBD  per-device write data (device to host).
dev_buff_wr  out  NBD  per-device buffer write strobe.
sd_lba  out  32  shared LBA.
sd_blk_cnt  out  6  shared block count.
sd_rd  out  1  shared read request.
sd_wr  out  1  shared write request.
sd_ack  in  1  host acknowledge.
sd_buff_wr  in  1  host buffer write strobe.
sd_buff_din  out  8  data muxed from the granted device.
busy  out  1  high while a transfer is granted.
grant  out  GW  index of the granted device.

Behaviour:
Reset: all outputs 0; rr_ptr=0; state=IDLE.

FSM states: IDLE, ISSUE, XFER.
- IDLE:
  - Requesters are the devices with dev_rd|dev_wr set.
  - Pick the first requester at or after rr_ptr, wrapping modulo NBD.
  - If one exists: register grant, sd_lba, sd_blk_cnt and op (rd wins if both rd and wr are set); set busy=1; go to ISSUE.
  - Latency: request visible in cycle t -> sd_rd/sd_wr high in cycle t+1.
- ISSUE:
  - Hold sd_rd (op=rd) or sd_wr (op=wr) at 1.
  - On sd_ack=1: drop sd_rd/sd_wr the same edge; go to XFER.
  - If the granted device withdraws both requests before ack: drop sd_rd/sd_wr; busy=0; rr_ptr=grant+1; go to IDLE (cancel; no dev_ack pulse).
- XFER:
  - Requests are ignored.
  - On sd_ack falling to 0: busy=0; rr_ptr=(grant+1) mod NBD; go to IDLE.
  - A new grant is possible one cycle after IDLE is entered, never on the same edge.

Combinational outputs, all from registered state:
- dev_ack[i] = sd_ack & busy & (grant==i).
- dev_buff_wr[i] = sd_buff_wr & busy & (grant==i).
- sd_buff_din = dev_buff_din[grant]; 0 when !busy.

Boundary rules:
- sd_lba and sd_blk_cnt hold the latched values for the whole grant; later dev_lba changes are ignored.
- sd_ack asserted while IDLE is ignored.
- rr_ptr wraps NBD-1 -> 0.
- NBD=1 degenerates to a registered passthrough.
- reset_n low mid-transfer aborts immediately, with all outputs 0 asynchronously.

Optional Feature:
Macro: IEEEDRV_SD_ARB_TIMEOUT_EN.
- With the macro:
  - A 24-bit watchdog clears on every state change and counts in ISSUE and XFER.
  - On reaching TIMEOUT_CYCLES: force sd_rd/sd_wr=0, busy=0, advance rr_ptr, go to IDLE.
  - Set sticky output port timeout (1 bit), cleared by reset only.
- Without the macro: no counter and no timeout port; the FSM waits indefinitely.

Decomposition:
Shared package ieeedrv_pkg holds:
- typedef sd_op_t enum {OP_RD, OP_WR};
- typedef arb_state_t enum {IDLE, ISSUE, XFER};
- localparam SD_BLK_CNT_W=6.

Sub-module ieeedrv_rr_pick:
- Combinational round-robin priority encoder.
- Inputs: req vector, rr_ptr.
- Outputs: valid and index.

Test Plan:
- Single read: dev_rd[0]=1, dev_lba[0]=32'h100, blk_cnt=0; sd_ack high 3 cycles later for 20 cycles -> sd_rd high one cycle after request until ack, sd_lba=32'h100, dev_ack[0] mirrors sd_ack, dev_ack[1]=0, busy falls the cycle after ack falls.
- Contention: dev_rd[0] and dev_wr[1] both set after reset -> device 0 is granted first (sd_rd), then device 1 (sd_wr); next simultaneous requests give device 0 again because rr_ptr wrapped.
- Buffer routing: grant=1, dev_buff_din[1]=8'hA5, dev_buff_din[0]=8'h3C, sd_buff_wr pulses -> sd_buff_din=8'hA5, dev_buff_wr=2'b10.
- Cancel: dev_rd[0] dropped in ISSUE before sd_ack -> sd_rd=0 next cycle, busy=0, no dev_ack pulse, device 1 is serviced next if requesting.
- Reset mid-XFER: reset_n low while sd_ack=1 -> all outputs 0 immediately; after release the FSM is IDLE with rr_ptr=0.
- With IEEEDRV_SD_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=100: sd_ack never asserted -> sd_rd drops at cycle 100, timeout=1, busy=0.
